// File: rtl/data_memory_arbiter.sv
// Two-master round-robin arbiter in front of a single-ported data memory.
// One access is outstanding at a time; misaligned accesses are answered locally with an error strobe.
module data_memory_arbiter #(
    parameter int READ_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    input  logic [1:0]  m0_mode,
    input  logic        m0_unsigned,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic [1:0]  m1_mode,
    input  logic        m1_unsigned,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic [1:0]  mem_mode,
    output logic        mem_unsigned,
    output logic        mem_wren,
    input  logic [31:0] mem_q
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;

    function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] addr_lo);
        logic mis;
        case (mode)
            MODE_BYTE: mis = 1'b0;
            MODE_HALF: mis = addr_lo[0];
            default:   mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

    logic [0:0]  state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  mode_q, mode_d;
    logic        uns_q, uns_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        gnt0_s, gnt1_s, any_gnt_s, mis_s;
    logic [31:0] sel_addr_s, sel_wdata_s;
    logic [1:0]  sel_mode_s;
    logic        sel_we_s, sel_uns_s;

    // Round-robin grant: on contention the master not granted last wins; ptr_q holds the last grantee.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset && (state_q == ST_IDLE)) begin
            if (m0_req && (!m1_req || ptr_q)) begin
                gnt0_s = 1'b1;
            end else if (m1_req) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b0;
            end
        end else begin
            gnt0_s = 1'b0;
        end
        any_gnt_s   = gnt0_s | gnt1_s;
        sel_addr_s  = gnt1_s ? m1_addr     : m0_addr;
        sel_wdata_s = gnt1_s ? m1_wdata    : m0_wdata;
        sel_mode_s  = gnt1_s ? m1_mode     : m0_mode;
        sel_we_s    = gnt1_s ? m1_we       : m0_we;
        sel_uns_s   = gnt1_s ? m1_unsigned : m0_unsigned;
        mis_s       = is_misaligned(sel_mode_s, sel_addr_s[1:0]);
    end

    // Memory-side drive: granted request in the grant cycle, held load attributes while waiting.
    always_comb begin
        mem_address  = 32'd0;
        mem_data     = 32'd0;
        mem_mode     = 2'b00;
        mem_unsigned = 1'b0;
        mem_wren     = 1'b0;
        if (!reset) begin
            mem_wren = 1'b0;
        end else if (any_gnt_s) begin
            mem_address  = sel_addr_s;
            mem_data     = sel_wdata_s;
            mem_mode     = sel_mode_s;
            mem_unsigned = sel_uns_s;
            mem_wren     = sel_we_s & ~mis_s;
        end else if (state_q == ST_WAIT) begin
            mem_address  = addr_q;
            mem_mode     = mode_q;
            mem_unsigned = uns_q;
        end else begin
            mem_wren = 1'b0;
        end
    end

    // Next-state logic for the IDLE/WAIT sequencer and the per-master response strobes.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        mode_d   = mode_q;
        uns_d    = uns_q;
        rvalid_d = 2'b00;
        err_d    = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (any_gnt_s) begin
                    ptr_d = gnt1_s;
                    if (mis_s) begin
                        err_d[gnt1_s] = 1'b1;
                        if (!sel_we_s) begin
                            rvalid_d[gnt1_s] = 1'b1;
                            if (gnt1_s) begin
                                rdata1_d = 32'd0;
                            end else begin
                                rdata0_d = 32'd0;
                            end
                        end else begin
                            rvalid_d = 2'b00;
                        end
                    end else if (!sel_we_s) begin
                        state_d = ST_WAIT;
                        cnt_d   = 3'(READ_LAT);
                        owner_d = gnt1_s;
                        addr_d  = sel_addr_s;
                        mode_d  = sel_mode_s;
                        uns_d   = sel_uns_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // cnt_q reaches 1 in the last cycle mem_q is expected to be valid.
                if (cnt_q == 3'd1) begin
                    state_d           = ST_IDLE;
                    cnt_d             = 3'd0;
                    rvalid_d[owner_q] = 1'b1;
                    if (owner_q) begin
                        rdata1_d = mem_q;
                    end else begin
                        rdata0_d = mem_q;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b1;
            cnt_q    <= 3'd0;
            owner_q  <= 1'b0;
            addr_q   <= 32'd0;
            mode_q   <= 2'b00;
            uns_q    <= 1'b0;
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            mode_q   <= mode_d;
            uns_q    <= uns_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign m0_gnt    = gnt0_s;
    assign m1_gnt    = gnt1_s;
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: a transaction-level model predicts grants and
// responses, a separate monitor pops expected responses whenever the DUT strobes rvalid/err.
module tb_data_memory_arbiter;

    localparam int LAT = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req, m0_we, m0_unsigned, m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [1:0]  m0_mode;
    logic        m1_req, m1_we, m1_unsigned, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [1:0]  m1_mode;
    logic [31:0] mem_address, mem_data, mem_q;
    logic [1:0]  mem_mode;
    logic        mem_unsigned, mem_wren;

    data_memory_arbiter #(.READ_LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_mode(m0_mode), .m0_unsigned(m0_unsigned), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_mode(m1_mode), .m1_unsigned(m1_unsigned), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_address(mem_address), .mem_data(mem_data), .mem_mode(mem_mode),
        .mem_unsigned(mem_unsigned), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] wd;
        bit          we;
        logic [1:0]  md;
        bit          un;
    } txn_t;

    typedef struct {
        int          m;
        bit          rv;
        bit          er;
        logic [31:0] data;
        int          due;
    } exp_t;

    txn_t q0[$];
    txn_t q1[$];
    exp_t sb[$];
    logic [31:0] mem_model [logic [31:0]];

    int total = 0;
    int bad = 0;
    bit started = 1'b0;
    bit gseen0 = 1'b0;
    bit gseen1 = 1'b0;
    int ld_cycle = -1;
    logic [31:0] ld_data = 32'd0;
    int busy_until = 0;
    bit last = 1'b1;
    logic [31:0] h_addr = 32'd0;
    logic [1:0]  h_mode = 2'd0;
    bit          h_uns = 1'b0;
    logic [31:0] rd_model0 = 32'd0;
    logic [31:0] rd_model1 = 32'd0;
    int wc0 = 0;
    int wc1 = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit is_mis(input logic [1:0] md, input logic [31:0] a);
        if (md == 2'd0) return 1'b0;
        if (md == 2'd1) return a[0];
        return a[1:0] != 2'd0;
    endfunction

    // Reference model: grant prediction, memory-side checks, response scheduling.
    always @(negedge clock) begin
        gseen0 = m0_gnt;
        gseen1 = m1_gnt;
        if (started) begin
            if (!reset) begin
                check("gnt_in_reset", {m0_gnt, m1_gnt}, 72'd0);
                check("wren_in_reset", mem_wren, 72'd0);
                busy_until = 0;
                last = 1'b1;
                ld_cycle = -1;
                for (int i = sb.size() - 1; i >= 0; i--)
                    if (sb[i].due > cyc) sb.delete(i);
            end else if (cyc < busy_until) begin
                check("gnt_in_wait", {m0_gnt, m1_gnt}, 72'd0);
                check("wren_in_wait", mem_wren, 72'd0);
                check("held_addr", mem_address, h_addr);
                check("held_mode_uns", {mem_mode, mem_unsigned}, {h_mode, h_uns});
            end else begin
                int g;
                g = -1;
                if (m0_req && m1_req) g = last ? 0 : 1;
                else if (m0_req) g = 0;
                else if (m1_req) g = 1;
                check("gnt", {m0_gnt, m1_gnt}, (g == 0) ? 72'd2 : (g == 1) ? 72'd1 : 72'd0);
                if (g < 0) begin
                    check("mem_idle", {mem_wren, mem_address, mem_data, mem_mode, mem_unsigned}, 72'd0);
                end else begin
                    logic [31:0] a, wd, d;
                    logic [1:0] md;
                    bit we, un, mis;
                    a  = g ? m1_addr : m0_addr;
                    wd = g ? m1_wdata : m0_wdata;
                    md = g ? m1_mode : m0_mode;
                    we = g ? m1_we : m0_we;
                    un = g ? m1_unsigned : m0_unsigned;
                    mis = is_mis(md, a);
                    check("mem_address", mem_address, a);
                    check("mem_data", mem_data, wd);
                    check("mem_mode_uns", {mem_mode, mem_unsigned}, {md, un});
                    check("mem_wren", mem_wren, we && !mis);
                    last = g[0];
                    if (mis) begin
                        sb.push_back('{g, !we, 1'b1, 32'd0, cyc + 1});
                    end else if (we) begin
                        mem_model[a] = wd;
                    end else begin
                        d = mem_model.exists(a) ? mem_model[a] : (a ^ 32'h5A5A_C3C3);
                        busy_until = cyc + LAT + 1;
                        ld_cycle = cyc + LAT;
                        ld_data = d;
                        h_addr = a;
                        h_mode = md;
                        h_uns = un;
                        sb.push_back('{g, 1'b1, 1'b0, d, cyc + LAT + 1});
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a response strobe appears, checks rdata hold.
    always @(negedge clock) begin
        if (started) begin
            if (m0_rvalid || m0_err || m1_rvalid || m1_err) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp cycle %0d: got rv/err %b%b%b%b expected none",
                             cyc, m0_rvalid, m0_err, m1_rvalid, m1_err);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_cycle", cyc, e.due);
                    check("resp_flags", {m0_rvalid, m0_err, m1_rvalid, m1_err},
                          (e.m == 0) ? {68'd0, e.rv, e.er, 2'b00} : {70'd0, e.rv, e.er});
                    if (e.rv && e.m == 0) rd_model0 = e.data;
                    if (e.rv && e.m == 1) rd_model1 = e.data;
                end
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                total++;
                bad++;
                $display("FAIL resp_missing cycle %0d: got nothing expected response due %0d",
                         cyc, sb[0].due);
                void'(sb.pop_front());
            end
            check("m0_rdata", m0_rdata, rd_model0);
            check("m1_rdata", m1_rdata, rd_model1);
            if (!reset) begin
                rd_model0 = 32'd0;
                rd_model1 = 32'd0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        if (gseen0 && q0.size() > 0) begin void'(q0.pop_front()); wc0 = 0; end
        if (gseen1 && q1.size() > 0) begin void'(q1.pop_front()); wc1 = 0; end
        if (q0.size() > 0) wc0++;
        if (q1.size() > 0) wc1++;
        if (wc0 > 40) begin total++; bad++; $display("FAIL m0_starved cycle %0d: got no grant expected one", cyc); void'(q0.pop_front()); wc0 = 0; end
        if (wc1 > 40) begin total++; bad++; $display("FAIL m1_starved cycle %0d: got no grant expected one", cyc); void'(q1.pop_front()); wc1 = 0; end
        m0_req = q0.size() > 0;
        m1_req = q1.size() > 0;
        {m0_addr, m0_wdata, m0_we, m0_mode, m0_unsigned} = m0_req ? {q0[0].a, q0[0].wd, q0[0].we, q0[0].md, q0[0].un} : 68'd0;
        {m1_addr, m1_wdata, m1_we, m1_mode, m1_unsigned} = m1_req ? {q1[0].a, q1[0].wd, q1[0].we, q1[0].md, q1[0].un} : 68'd0;
        mem_q = (cyc == ld_cycle) ? ld_data : $urandom();
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (q0.size() > 0 || q1.size() > 0 || sb.size() > 0 || cyc <= busy_until); k++)
            step();
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.a  = {26'd0, 6'($urandom_range(0, 63))} | (($urandom_range(0, 1) == 1) ? 32'h0001_0000 : 32'd0);
        t.wd = $urandom();
        t.we = $urandom_range(0, 1) == 1;
        t.md = 2'($urandom_range(0, 2));
        t.un = $urandom_range(0, 1) == 1;
        return t;
    endfunction

    initial begin
        m0_req = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_we = 1'b0; m0_mode = 2'd0; m0_unsigned = 1'b0;
        m1_req = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_we = 1'b0; m1_mode = 2'd0; m1_unsigned = 1'b0;
        mem_q = 32'd0;
        reset = 1'b0;
        step();
        step();
        started = 1'b1;
        @(negedge clock);
        check("reset_state", {m0_rvalid, m0_err, m1_rvalid, m1_err, mem_wren, m0_rdata, m1_rdata}, 72'd0);
        reset = 1'b1;
        // Continuous stores from both masters must alternate starting with m0.
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1, 2'd2, 1'b0});
            q1.push_back('{32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b1, 2'd2, 1'b0});
        end
        drain();
        q0.push_back('{32'h10, 32'd0, 1'b0, 2'd2, 1'b0});
        drain();
        q1.push_back('{32'h3, 32'h1234_5678, 1'b1, 2'd1, 1'b0});
        drain();
        // Load read-back of an earlier store while the other master waits on it.
        q0.push_back('{32'h104, 32'd0, 1'b0, 2'd2, 1'b0});
        q1.push_back('{32'h20C, 32'd0, 1'b0, 2'd2, 1'b1});
        drain();
        q0.push_back('{32'h21, 32'd0, 1'b0, 2'd0, 1'b1});
        q0.push_back('{32'h22, 32'd0, 1'b0, 2'd2, 1'b0});
        drain();
        // Reset one cycle after a load grant must discard the load.
        q0.push_back('{32'h108, 32'd0, 1'b0, 2'd2, 1'b0});
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        step();
        drain();
        for (int n = 0; n < 1500; n++) begin
            if (q0.size() == 0 && $urandom_range(0, 2) != 0) q0.push_back(rand_txn());
            if (q1.size() == 0 && $urandom_range(0, 2) != 0) q1.push_back(rand_txn());
            reset = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            step();
        end
        reset = 1'b1;
        drain();
        step();
        check("scoreboard_empty", sb.size(), 72'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 The block SHALL have parameter READ_LAT, default 1, meaning cycles from grant to valid mem_q; legal range 1..4.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have ports m0_req/m1_req, input, 1, access request held until granted.
REQ-005 The block SHALL have ports m0_addr/m1_addr, input, 32, byte address.
REQ-006 The block SHALL have ports m0_wdata/m1_wdata, input, 32, store data.
REQ-007 The block SHALL have ports m0_we/m1_we, input, 1, 1=store, 0=load.
REQ-008 The block SHALL have ports m0_mode/m1_mode, input, 2, byte/half/word memory mode code.
REQ-009 The block SHALL have ports m0_unsigned/m1_unsigned, input, 1, unsigned load.
REQ-010 The block SHALL have ports m0_gnt/m1_gnt, output, 1, request accepted this cycle.
REQ-011 The block SHALL have ports m0_rvalid/m1_rvalid, output, 1, one-cycle load-data strobe.
REQ-012 The block SHALL have ports m0_rdata/m1_rdata, output, 32, load data, valid with rvalid.
REQ-013 The block SHALL have ports m0_err/m1_err, output, 1, one-cycle misaligned-access strobe.
REQ-014 The block SHALL have ports mem_address, mem_data (32), mem_mode (2), mem_unsigned, mem_wren (1), all outputs driving the data memory.
REQ-015 The block SHALL have port mem_q, input, 32, data memory read result.

Function
REQ-016 The block SHALL use states IDLE and WAIT; only one access outstanding.
REQ-017 In IDLE, when any req is high, the block SHALL assert exactly one gnt combinationally in that cycle (grant cycle T) and drive that master's addr/wdata/mode/unsigned onto mem_*.
REQ-018 Arbitration SHALL be round-robin: with both requesting, the master not granted last wins; last-grant pointer resets to m1, so m0 wins first.
REQ-019 A lone requester SHALL be granted regardless of the pointer; the pointer updates on every grant.
REQ-020 An aligned store SHALL drive mem_wren=1 only in cycle T; the state stays IDLE, allowing back-to-back grants in T+1.
REQ-021 A load SHALL drive mem_wren=0 in T, enter WAIT with counter=READ_LAT, and hold mem_address/mem_mode/mem_unsigned at the granted values through T+READ_LAT.
REQ-022 The block SHALL capture mem_q at the end of T+READ_LAT into the owner's rdata, pulse the owner's rvalid during T+READ_LAT+1, and return to IDLE at T+READ_LAT+1, where a new grant is allowed.
REQ-023 No gnt SHALL be asserted while in WAIT; requests are held by the masters.
REQ-024 An access is misaligned when mode=half with addr[0]=1, or mode=word with addr[1:0]!=0; byte accesses are never misaligned.
REQ-025 A misaligned access SHALL still be granted, with mem_wren forced to 0 and no WAIT entry; err and, for loads, rvalid with rdata=0 SHALL pulse in T+1.
REQ-026 When no grant is given in IDLE, mem_wren SHALL be 0 and the other mem_* outputs SHALL be 0.
REQ-027 rdata SHALL hold its last value between rvalid pulses.
REQ-028 The non-owning master's rvalid and err SHALL stay 0.

Reset
REQ-029 With reset=0 at a clock edge, the block SHALL enter IDLE, set the pointer to m1, clear the counter, and zero rvalid, err, rdata and mem_wren.
REQ-030 A load in flight during reset SHALL be discarded, with no rvalid.
REQ-031 Gnt SHALL be 0 in any cycle where reset=0.

Verification
REQ-032 m0 word load at 0x10, READ_LAT=1, mem_q=0xDEADBEEF at T+1 -> m0_gnt at T, m0_rvalid with rdata=0xDEADBEEF at T+2, idle at T+2.
REQ-033 Both masters request stores continuously after reset -> grants alternate m0,m1,m0,m1 on consecutive cycles, with mem_wren=1 each cycle.
REQ-034 m1 half store at 0x3 -> m1_gnt, mem_wren=0, m1_err pulse next cycle, m0 unaffected.
REQ-035 m0 load at READ_LAT=3 while m1 requests -> no m1_gnt for T+1..T+3; m1_gnt at T+4.
REQ-036 reset=0 at T+1 of a READ_LAT=2 load -> no rvalid, and outputs are zero next cycle.
REQ-037 m0 byte load of unsigned=1 -> mem_unsigned=1 held through the data-return cycle.
